decinv_ctrl: RTL and testbench

DECINV_CTRL -- requirements
Module: decinv_ctrl

---
 rtl/decinv_pkg.sv | 41 ++++
 rtl/decinv_tick_gen.sv | 33 +++
 rtl/decinv_ctrl.sv | 105 ++++++++++
 tb/tb_decinv_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/decinv_pkg.sv
// Shared types and constants for the level-driven inverse-decode run controller.
// DECINV_CTRL_WRAP_EN: level wraps 4->0 / 0->4 instead of saturating.
package decinv_pkg;

    localparam int LEVEL_MAX = 4;
    localparam int CODE_W    = 4;
    localparam int LEVEL_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Opposing requests in the same cycle cancel out.
    function automatic logic [LEVEL_W-1:0] level_next(
        input logic [LEVEL_W-1:0] lvl,
        input logic               up,
        input logic               dn
    );
        logic [LEVEL_W-1:0] nxt;
        nxt = lvl;
        if (up && !dn) begin
`ifdef DECINV_CTRL_WRAP_EN
            nxt = (lvl == LEVEL_W'(LEVEL_MAX)) ? '0 : lvl + 1'b1;
`else
            nxt = (lvl == LEVEL_W'(LEVEL_MAX)) ? lvl : lvl + 1'b1;
`endif
        end else if (dn && !up) begin
`ifdef DECINV_CTRL_WRAP_EN
            nxt = (lvl == '0) ? LEVEL_W'(LEVEL_MAX) : lvl - 1'b1;
`else
            nxt = (lvl == '0) ? lvl : lvl - 1'b1;
`endif
        end
        return nxt;
    endfunction

endpackage

// File: rtl/decinv_tick_gen.sv
// Run prescaler: one tick every TICK_DIV cycles, counting from zero after clear.
module decinv_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);

    localparam int                 CNT_W = $clog2(TICK_DIV + 1);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = !clear_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || tick_o)
            cnt_d = '0;
        else
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/decinv_ctrl.sv
// Level register plus run FSM: issues the level to an external inverse decoder and
// runs for decode*TICK_DIV cycles. Wrap behaviour selected by DECINV_CTRL_WRAP_EN.
module decinv_ctrl
    import decinv_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              up_i,
    input  logic              down_i,
    input  logic              start_i,
    input  logic              abort_i,
    output logic [CODE_W-1:0] code_o,
    input  logic [CODE_W-1:0] dec_i,
    output logic [LEVEL_W-1:0] level_o,
    output logic              busy_o,
    output logic              run_o,
    output logic              done_o,
    output logic              err_o
);

    state_e             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [CODE_W-1:0]  cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               tick;

    // Prescaler is held clear outside RUN so every run starts a fresh tick period.
    decinv_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .rst_n   (reset),
        .clear_i (state_q != ST_RUN),
        .tick_o  (tick)
    );

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                level_d = level_next(level_q, up_i, down_i);
                err_d   = 1'b0;
                if (start_i)
                    state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = abort_i ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                if (abort_i) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = dec_i;
                    if (dec_i == '0) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    state_d = ST_DONE;
                end else if (tick) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CODE_W'(1))
                        state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            level_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign code_o  = {{(CODE_W-LEVEL_W){1'b0}}, level_q};
    assign level_o = level_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign run_o   = (state_q == ST_RUN);
    assign done_o  = (state_q == ST_DONE);
    assign err_o   = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_decinv_ctrl.sv
// Bench for decinv_ctrl with TICK_DIV=4 and a registered decoder mapping level 0..4 -> 5..1.
module tb_decinv_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       up_i = 1'b0, down_i = 1'b0, start_i = 1'b0, abort_i = 1'b0;
    logic [3:0] code_o, dec_i;
    logic [3:0] dec_q = 4'd0;
    logic [2:0] level_o;
    logic       busy_o, run_o, done_o, err_o;
    logic       force_zero = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decinv_ctrl #(.TICK_DIV(TD)) dut (
        .clk     (clk),
        .reset   (reset),
        .up_i    (up_i),
        .down_i  (down_i),
        .start_i (start_i),
        .abort_i (abort_i),
        .code_o  (code_o),
        .dec_i   (dec_i),
        .level_o (level_o),
        .busy_o  (busy_o),
        .run_o   (run_o),
        .done_o  (done_o),
        .err_o   (err_o)
    );

    // External decoder: registered, one cycle behind code_o.
    always @(posedge clk) dec_q <= (code_o <= 4'd4) ? 4'(5 - code_o) : 4'd0;
    assign dec_i = force_zero ? 4'd0 : dec_q;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int step_level(input int l, input bit up, input bit dn);
        if (up && !dn) begin
`ifdef DECINV_CTRL_WRAP_EN
            return (l == 4) ? 0 : l + 1;
`else
            return (l == 4) ? 4 : l + 1;
`endif
        end
        if (dn && !up) begin
`ifdef DECINV_CTRL_WRAP_EN
            return (l == 0) ? 4 : l - 1;
`else
            return (l == 0) ? 0 : l - 1;
`endif
        end
        return l;
    endfunction

    // Timeline model: a start accepted at edge s gives ISSUE after s, WAIT after s+1,
    // RUN over edges s+2 .. done_at-1 and the done pulse after edge done_at = s+2+dec*TD.
    int cyc = 0, m_level = 0, m_s = 0, m_done_at = -10;
    bit m_act = 1'b0, m_err = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc = 0; m_level = 0; m_act = 1'b0; m_err = 1'b0; m_done_at = -10;
        end else begin
            cyc = cyc + 1;
            if (!m_act || (cyc - 1 > m_done_at)) begin
                int dec;
                m_act   = 1'b0;
                m_level = step_level(m_level, up_i, down_i);
                if (start_i) begin
                    dec       = force_zero ? 0 : 5 - m_level;
                    m_act     = 1'b1;
                    m_s       = cyc;
                    m_done_at = cyc + 2 + dec * TD;
                    m_err     = (dec == 0);
                end
            end else if (abort_i && cyc <= m_done_at) begin
                m_done_at = cyc;
                m_err     = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            bit e_busy, e_run, e_done;
            e_busy = m_act && (cyc <= m_done_at);
            e_run  = m_act && (cyc >= m_s + 2) && (cyc < m_done_at);
            e_done = m_act && (cyc == m_done_at);
            check("level_o", int'(level_o), m_level);
            check("code_o",  int'(code_o),  m_level);
            check("busy_o",  int'(busy_o),  int'(e_busy));
            check("run_o",   int'(run_o),   int'(e_run));
            check("done_o",  int'(done_o),  int'(e_done));
            check("err_o",   int'(err_o),   int'(e_done && m_err));
        end
    end

    task automatic pulse_up(input int n);
        repeat (n) begin
            @(negedge clk); up_i = 1'b1;
            @(negedge clk); up_i = 1'b0;
        end
    endtask

    task automatic pulse_down(input int n);
        repeat (n) begin
            @(negedge clk); down_i = 1'b1;
            @(negedge clk); down_i = 1'b0;
        end
    endtask

    // Start a run; optionally abort or pulse up_i during a given RUN cycle (1-based).
    task automatic run_txn(input int abort_at, input int up_at,
                           output int runs, output int dones, output int errs);
        bit to;
        runs = 0; dones = 0; errs = 0; to = 1'b1;
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (run_o) runs++;
            abort_i = (abort_at > 0) && run_o && (runs == abort_at);
            up_i    = (up_at > 0) && run_o && (runs == up_at);
            if (err_o) errs++;
            if (done_o) begin
                dones++;
                to = 1'b0;
                abort_i = 1'b0; up_i = 1'b0;
                @(negedge clk);
                if (done_o) dones++;
                break;
            end
            @(negedge clk);
        end
        abort_i = 1'b0; up_i = 1'b0;
        check("txn_timeout", int'(to), 0);
    endtask

    task automatic apply_reset();
        @(negedge clk); #2 reset = 1'b0;
        @(negedge clk); @(negedge clk); reset = 1'b1;
    endtask

    int runs, dones, errs;

    initial begin
        #2 reset = 1'b0;
        #1;
        check("rst_busy",  int'(busy_o),  0);
        check("rst_run",   int'(run_o),   0);
        check("rst_done",  int'(done_o),  0);
        check("rst_err",   int'(err_o),   0);
        check("rst_code",  int'(code_o),  0);
        check("rst_level", int'(level_o), 0);
        @(negedge clk); @(negedge clk); reset = 1'b1;

        // Level 0 decodes to 5: 5*4 run cycles.
        run_txn(0, 0, runs, dones, errs);
        check("l0_runs", runs, 20); check("l0_dones", dones, 1); check("l0_errs", errs, 0);

        pulse_up(5);
        @(negedge clk);
`ifdef DECINV_CTRL_WRAP_EN
        check("up5_level", int'(level_o), 0);
        run_txn(0, 0, runs, dones, errs);
        check("up5_runs", runs, 20);
`else
        check("up5_level", int'(level_o), 4);
        run_txn(0, 0, runs, dones, errs);
        check("up5_runs", runs, 4);
`endif
        check("up5_dones", dones, 1);

        apply_reset();
        pulse_up(2);
        @(negedge clk); up_i = 1'b1; down_i = 1'b1;
        @(negedge clk); up_i = 1'b0; down_i = 1'b0;
        @(negedge clk);
        check("updn_level", int'(level_o), 2);
        run_txn(0, 5, runs, dones, errs);
        check("l2_runs", runs, 12);
        check("l2_level_after", int'(level_o), 2);

        pulse_down(2);
        run_txn(7, 0, runs, dones, errs);
        check("abort_runs", runs, 7); check("abort_dones", dones, 1); check("abort_errs", errs, 0);

        force_zero = 1'b1;
        run_txn(0, 0, runs, dones, errs);
        force_zero = 1'b0;
        check("zero_runs", runs, 0); check("zero_dones", dones, 1); check("zero_errs", errs, 1);

        // Asynchronous reset in the middle of a run.
        pulse_up(2);
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_run", int'(run_o), 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_run",   int'(run_o),   0);
        check("mid_rst_busy",  int'(busy_o),  0);
        check("mid_rst_level", int'(level_o), 0);
        check("mid_rst_done",  int'(done_o),  0);
        @(negedge clk);
        check("mid_rst_done2", int'(done_o), 0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_busy", int'(busy_o), 0);
        run_txn(0, 0, runs, dones, errs);
        check("resume_runs", runs, 20); check("resume_dones", dones, 1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
